// File: rtl/ryu_anim_ctrl_if.sv
// Control/status bundle for the Ryu animation controller.
// master: the side producing frame ticks and key levels; slave: the controller.
interface ryu_anim_ctrl_if;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic       key_punch;
    logic       hit;
    logic [3:0] sprite;
    logic [9:0] RyuX;
    logic [9:0] RyuY;
    logic       attack_active;
    logic       busy;

    modport master (
        output frame_tick, key_left, key_right, key_up, key_down, key_punch, hit,
        input  sprite, RyuX, RyuY, attack_active, busy
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_up, key_down, key_punch, hit,
        output sprite, RyuX, RyuY, attack_active, busy
    );
endinterface

// File: rtl/ryu_anim_ctrl.sv
// Ryu character animation controller: frame-tick driven state machine that
// produces a sprite selector and anchor position from level-sampled keys.
// Optional idle breathing animation: define RYU_IDLE_PULSE_EN.
module ryu_anim_ctrl #(
    parameter logic [9:0] X_MIN        = 10'd16,
    parameter logic [9:0] X_MAX        = 10'd560,
    parameter logic [9:0] GROUND_Y     = 10'd300,
    parameter logic [9:0] WALK_STEP    = 10'd2,
    parameter logic [9:0] JUMP_STEP    = 10'd4,
    parameter logic [5:0] JUMP_HALF    = 6'd16,
    parameter logic [5:0] PUNCH_FRAMES = 6'd12,
    parameter logic [5:0] PULSE_PERIOD = 6'd30
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    ryu_anim_ctrl_if.slave  io
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WALK_L = 3'd1;
    localparam logic [2:0] S_WALK_R = 3'd2;
    localparam logic [2:0] S_CROUCH = 3'd3;
    localparam logic [2:0] S_PUNCH  = 3'd4;
    localparam logic [2:0] S_JUMP   = 3'd5;
    localparam logic [2:0] S_JATK   = 3'd6;
    localparam logic [2:0] S_DEATH  = 3'd7;

    // One shared counter: punch frames remaining, or jump phase (0..2*JUMP_HALF).
    localparam logic [6:0] PUNCH_LOAD = {1'b0, PUNCH_FRAMES - 6'd1};
    localparam logic [6:0] JUMP_END   = {JUMP_HALF, 1'b0};

    logic [2:0] st_q, st_d, ev_st;
    logic [9:0] x_q, x_d, ev_x;
    logic [9:0] y_q, y_d;
    logic [6:0] cnt_q, cnt_d, ev_cnt;
    logic [3:0] sprite_q, sprite_d;
    logic       atk_q, busy_q;
    logic       pph_d;

    // Key evaluation used whenever the character is free to act.
    always_comb begin
        ev_st  = S_IDLE;
        ev_x   = x_q;
        ev_cnt = 7'd0;
        if (io.key_up) begin
            ev_st = S_JUMP;
        end else if (io.key_punch) begin
            ev_st  = S_PUNCH;
            ev_cnt = PUNCH_LOAD;
        end else if (io.key_down) begin
            ev_st = S_CROUCH;
        end else if (io.key_left && !io.key_right) begin
            ev_st = S_WALK_L;
            ev_x  = (x_q >= X_MIN + WALK_STEP) ? x_q - WALK_STEP : X_MIN;
        end else if (io.key_right && !io.key_left) begin
            ev_st = S_WALK_R;
            ev_x  = (x_q <= X_MAX - WALK_STEP) ? x_q + WALK_STEP : X_MAX;
        end
    end

    // Next state: hit wins over any tick; DEATH holds until reset.
    always_comb begin
        st_d  = st_q;
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        if (st_q != S_DEATH) begin
            if (io.hit) begin
                st_d  = S_DEATH;
                y_d   = GROUND_Y;
                cnt_d = 7'd0;
            end else if (io.frame_tick) begin
                case (st_q)
                    S_PUNCH: begin
                        if (cnt_q == 7'd0) begin
                            st_d  = ev_st;
                            x_d   = ev_x;
                            cnt_d = ev_cnt;
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                        end
                    end
                    S_JUMP, S_JATK: begin
                        if (cnt_q == JUMP_END) begin
                            st_d  = ev_st;
                            x_d   = ev_x;
                            cnt_d = ev_cnt;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                            y_d   = (cnt_q < {1'b0, JUMP_HALF}) ? y_q - JUMP_STEP
                                                                : y_q + JUMP_STEP;
                            if (st_q == S_JUMP && io.key_punch) st_d = S_JATK;
                        end
                    end
                    default: begin
                        st_d  = ev_st;
                        x_d   = ev_x;
                        cnt_d = ev_cnt;
                    end
                endcase
            end
        end
    end

`ifdef RYU_IDLE_PULSE_EN
    logic [5:0] pcnt_q, pcnt_d;
    logic       pph_q;

    // Breathing phase: toggles every PULSE_PERIOD ticks spent in IDLE.
    always_comb begin
        pcnt_d = pcnt_q;
        pph_d  = pph_q;
        if (st_d != S_IDLE || st_q != S_IDLE) begin
            pcnt_d = 6'd0;
            pph_d  = 1'b0;
        end else if (io.frame_tick) begin
            if (pcnt_q == PULSE_PERIOD - 6'd1) begin
                pcnt_d = 6'd0;
                pph_d  = ~pph_q;
            end else begin
                pcnt_d = pcnt_q + 6'd1;
            end
        end
    end

    // Breathing counter registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= 6'd0;
            pph_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            pph_q  <= pph_d;
        end
    end
`else
    // No breathing: IDLE always shows stand; the period only matters when enabled.
    assign pph_d = 1'b0 & (|PULSE_PERIOD);
`endif

    // Sprite code follows the next state so it changes on the same edge.
    always_comb begin
        sprite_d = 4'd0;
        case (st_d)
            S_IDLE:   sprite_d = {3'b000, pph_d};
            S_WALK_L: sprite_d = 4'd5;
            S_WALK_R: sprite_d = 4'd6;
            S_CROUCH: sprite_d = 4'd4;
            S_PUNCH:  sprite_d = 4'd2;
            S_JUMP:   sprite_d = 4'd3;
            S_JATK:   sprite_d = 4'd8;
            S_DEATH:  sprite_d = 4'd7;
            default:  sprite_d = 4'd0;
        endcase
    end

    // State, position and registered outputs.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q     <= S_IDLE;
            x_q      <= X_MIN;
            y_q      <= GROUND_Y;
            cnt_q    <= 7'd0;
            sprite_q <= 4'd0;
            atk_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            sprite_q <= sprite_d;
            atk_q    <= (st_d == S_PUNCH) || (st_d == S_JATK);
            busy_q   <= (st_d == S_PUNCH) || (st_d == S_JUMP) || (st_d == S_JATK);
        end
    end

    assign io.sprite        = sprite_q;
    assign io.RyuX          = x_q;
    assign io.RyuY          = y_q;
    assign io.attack_active = atk_q;
    assign io.busy          = busy_q;

endmodule

// File: tb/tb_ryu_anim_ctrl.sv
// Bench for ryu_anim_ctrl: directed key sequences, a frame-level model of the
// character checked every cycle, plus hand-computed spot values.
module tb_ryu_anim_ctrl;
    localparam int XMIN = 16, XMAX = 560, GY = 300, WS = 2, JS = 4;
    localparam int JH = 16, PF = 12, PP = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ryu_anim_ctrl_if bus();

    ryu_anim_ctrl dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .io      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_WL, M_WR, M_CR, M_PUNCH, M_JUMP, M_JATK, M_DEATH} mst_t;

    // Model: character action, x, jump age, punch frames shown, idle ticks.
    mst_t m_st = M_IDLE;
    int   mx = XMIN;
    int   jt = 0;
    int   pa = 0;
    int   it = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mst_t pick();
        if (bus.key_up)                          return M_JUMP;
        if (bus.key_punch)                       return M_PUNCH;
        if (bus.key_down)                        return M_CR;
        if (bus.key_left && !bus.key_right)      return M_WL;
        if (bus.key_right && !bus.key_left)      return M_WR;
        return M_IDLE;
    endfunction

    function automatic int exp_sprite(input mst_t s, input int idle_n);
        case (s)
`ifdef RYU_IDLE_PULSE_EN
            M_IDLE:  return (idle_n / PP) % 2;
`else
            M_IDLE:  return 0 * idle_n;
`endif
            M_PUNCH: return 2;
            M_JUMP:  return 3;
            M_CR:    return 4;
            M_WL:    return 5;
            M_WR:    return 6;
            M_DEATH: return 7;
            default: return 8;
        endcase
    endfunction

    function automatic int exp_y(input mst_t s, input int t);
        if (s == M_JUMP || s == M_JATK) return GY - JS * ((t <= JH) ? t : 2 * JH - t);
        return GY;
    endfunction

    // Model update on each clock edge.
    always @(posedge clk or negedge rst_n) begin : model
        mst_t s, n;
        int x, t, p, i;
        bit free;
        if (!rst_n) begin
            m_st <= M_IDLE; mx <= XMIN; jt <= 0; pa <= 0; it <= 0;
        end else if (m_st != M_DEATH) begin
            s = m_st; x = mx; t = jt; p = pa; i = it;
            if (bus.hit) begin
                s = M_DEATH;
            end else if (bus.frame_tick) begin
                free = (s == M_IDLE || s == M_WL || s == M_WR || s == M_CR) ||
                       (s == M_PUNCH && p == PF) ||
                       ((s == M_JUMP || s == M_JATK) && t == 2 * JH);
                if (free) begin
                    n = pick();
                    i = (n == M_IDLE && s == M_IDLE) ? i + 1 : 0;
                    t = 0;
                    p = 1;
                    if (n == M_WL) x = (x - WS < XMIN) ? XMIN : x - WS;
                    if (n == M_WR) x = (x + WS > XMAX) ? XMAX : x + WS;
                    s = n;
                end else if (s == M_PUNCH) begin
                    p = p + 1;
                end else begin
                    t = t + 1;
                    if (s == M_JUMP && bus.key_punch) s = M_JATK;
                end
            end
            m_st <= s; mx <= x; jt <= t; pa <= p; it <= i;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("sprite", int'(bus.sprite), exp_sprite(m_st, it));
        chk("RyuX", int'(bus.RyuX), mx);
        chk("RyuY", int'(bus.RyuY), exp_y(m_st, jt));
        chk("attack_active", int'(bus.attack_active), int'(m_st == M_PUNCH || m_st == M_JATK));
        chk("busy", int'(bus.busy), int'(m_st == M_PUNCH || m_st == M_JUMP || m_st == M_JATK));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1;
            cyc(1);
            bus.frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic keys(input logic l, input logic r, input logic u, input logic d, input logic p);
        bus.key_left = l; bus.key_right = r; bus.key_up = u; bus.key_down = d; bus.key_punch = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.hit = 1'b0;
        keys(0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        cyc(3);
        chk("rst_sprite", int'(bus.sprite), 0);
        chk("rst_x", int'(bus.RyuX), 16);
        chk("rst_y", int'(bus.RyuY), 300);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_atk", int'(bus.attack_active), 0);
        rst_n = 1'b1;
        cyc(2);

        // Walk right to the right limit.
        keys(0, 1, 0, 0, 0);
        tick(1);
        chk("walkr_first_x", int'(bus.RyuX), 18);
        chk("walkr_sprite", int'(bus.sprite), 6);
        tick(299);
        chk("walkr_sat_x", int'(bus.RyuX), 560);
        chk("walkr_sat_sprite", int'(bus.sprite), 6);

        // Idle breathing window.
        keys(0, 0, 0, 0, 0);
        tick(1);
        tick(29);
        chk("idle29_sprite", int'(bus.sprite), 0);
        tick(1);
`ifdef RYU_IDLE_PULSE_EN
        chk("idle30_sprite", int'(bus.sprite), 1);
`else
        chk("idle30_sprite", int'(bus.sprite), 0);
`endif
        tick(30);
        chk("idle60_sprite", int'(bus.sprite), 0);

        // Punch with left held: 12 frames of punch, then walk left.
        keys(1, 0, 0, 0, 1);
        tick(1);
        keys(1, 0, 0, 0, 0);
        chk("punch_sprite", int'(bus.sprite), 2);
        chk("punch_atk", int'(bus.attack_active), 1);
        tick(11);
        chk("punch12_sprite", int'(bus.sprite), 2);
        chk("punch12_x", int'(bus.RyuX), 560);
        tick(1);
        chk("after_punch_sprite", int'(bus.sprite), 5);
        chk("after_punch_x", int'(bus.RyuX), 558);
        keys(0, 0, 0, 0, 0);
        tick(1);

        // Plain jump.
        keys(0, 0, 1, 0, 0);
        tick(1);
        keys(0, 1, 0, 0, 0);
        chk("jump_sprite", int'(bus.sprite), 3);
        tick(16);
        chk("jump_apex_y", int'(bus.RyuY), 236);
        chk("jump_apex_x", int'(bus.RyuX), 558);
        tick(16);
        chk("jump_land_y", int'(bus.RyuY), 300);
        chk("jump_land_busy", int'(bus.busy), 1);
        keys(0, 0, 0, 0, 0);
        tick(1);
        chk("jump_done_sprite", int'(bus.sprite), 0);
        chk("jump_done_busy", int'(bus.busy), 0);

        // Jump attack.
        keys(0, 0, 1, 0, 0);
        tick(1);
        keys(0, 0, 0, 0, 0);
        tick(5);
        keys(0, 0, 0, 0, 1);
        tick(1);
        keys(0, 0, 0, 0, 0);
        chk("jatk_sprite", int'(bus.sprite), 8);
        chk("jatk_atk", int'(bus.attack_active), 1);
        chk("jatk_y", int'(bus.RyuY), 276);
        tick(26);
        chk("jatk_land_sprite", int'(bus.sprite), 8);
        chk("jatk_land_y", int'(bus.RyuY), 300);
        tick(1);
        chk("jatk_done_sprite", int'(bus.sprite), 0);

        // Conflicting keys.
        keys(1, 1, 0, 0, 0);
        tick(1);
        chk("lr_sprite", int'(bus.sprite), 0);
        keys(1, 0, 0, 1, 0);
        tick(1);
        chk("down_left_sprite", int'(bus.sprite), 4);
        keys(0, 0, 1, 0, 1);
        tick(1);
        chk("up_punch_sprite", int'(bus.sprite), 3);
        keys(0, 0, 0, 0, 0);
        tick(33);

        // Reset mid-jump.
        keys(0, 0, 1, 0, 0);
        tick(1);
        keys(0, 0, 0, 0, 0);
        tick(5);
        do_reset();
        chk("midjump_rst_sprite", int'(bus.sprite), 0);
        chk("midjump_rst_y", int'(bus.RyuY), 300);
        tick(2);
        chk("post_rst_y", int'(bus.RyuY), 300);

        // Hit between ticks during a jump.
        keys(0, 0, 1, 0, 0);
        tick(1);
        keys(0, 0, 0, 0, 0);
        tick(3);
        bus.hit = 1'b1;
        cyc(1);
        bus.hit = 1'b0;
        chk("death_sprite", int'(bus.sprite), 7);
        chk("death_y", int'(bus.RyuY), 300);
        chk("death_busy", int'(bus.busy), 0);
        keys(0, 0, 1, 0, 1);
        tick(2);
        chk("death_hold_sprite", int'(bus.sprite), 7);
        keys(0, 0, 0, 0, 0);
        do_reset();
        chk("death_rst_sprite", int'(bus.sprite), 0);
        chk("death_rst_x", int'(bus.RyuX), 16);

        // Left saturation at X_MIN.
        keys(1, 0, 0, 0, 0);
        tick(1);
        chk("walkl_sat_x", int'(bus.RyuX), 16);
        chk("walkl_sprite", int'(bus.sprite), 5);
        keys(0, 0, 0, 0, 0);
        tick(1);

        // Hit together with a tick: death wins, no step taken.
        keys(0, 1, 0, 0, 0);
        bus.hit = 1'b1;
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        keys(0, 0, 0, 0, 0);
        chk("hit_tick_sprite", int'(bus.sprite), 7);
        chk("hit_tick_x", int'(bus.RyuX), 16);
        cyc(2);
        do_reset();
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ryu_anim_ctrl.md
RYU_ANIM_CTRL -- requirements
Module: ryu_anim_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_MIN, 10'd16, left position limit.
- X_MAX, 10'd560, right position limit.
- GROUND_Y, 10'd300, standing RyuY.
- WALK_STEP, 10'd2, pixels per frame walked.
- JUMP_STEP, 10'd4, pixels per frame vertical.
- JUMP_HALF, 6'd16, rising frames; falling frames equal.
- PUNCH_FRAMES, 6'd12, punch hold length.
- PULSE_PERIOD, 6'd30, idle stand/pulse toggle period.
REQ-002 vga_clk  in  1  sole clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 frame_tick  in  1  one-cycle pulse per video frame; all motion and animation advance only on it.
REQ-005 key_left, key_right, key_up, key_down, key_punch  in  1 each  level-sampled controls.
REQ-006 hit  in  1  death trigger, sampled every cycle.
REQ-007 sprite  out  4  selector code: 0 stand, 1 pulse, 2 punch, 3 jump, 4 crouch, 5 walk left, 6 walk right, 7 death, 8 jump attack; 9-15 never driven.
REQ-008 RyuX, RyuY  out  10 each  sprite anchor position.
REQ-009 attack_active  out  1  high in PUNCH and JATK states.
REQ-010 busy  out  1  high in PUNCH, JUMP, JATK; inputs other than hit ignored while high.

Function
REQ-011 States: IDLE, WALK_L, WALK_R, CROUCH, PUNCH, JUMP, JATK, DEATH; all outputs registered.
REQ-012 Without frame_tick, state, counters, positions and sprite hold, except hit handling (REQ-020).
REQ-013 At frame_tick from IDLE/WALK_L/WALK_R/CROUCH, next state by priority: key_up -> JUMP; key_punch -> PUNCH; key_down -> CROUCH; key_left only -> WALK_L; key_right only -> WALK_R; both or neither -> IDLE.
REQ-014 WALK_L: RyuX -= WALK_STEP each frame, saturating at X_MIN; WALK_R: RyuX += WALK_STEP, saturating at X_MAX; no wrap-around; applied on the tick that enters or stays in the walk state.
REQ-015 PUNCH: frame counter loaded with PUNCH_FRAMES-1 on entry; decrements per tick; at 0 the next tick re-evaluates REQ-013; sprite 2 held for exactly PUNCH_FRAMES frames.
REQ-016 JUMP: phase counter from 0; for counts 0..JUMP_HALF-1 RyuY -= JUMP_STEP, for JUMP_HALF..2*JUMP_HALF-1 RyuY += JUMP_STEP; after 2*JUMP_HALF ticks RyuY == GROUND_Y exactly, then re-evaluate REQ-013 on the next tick.
REQ-017 key_punch during JUMP at a tick -> JATK, phase counter and trajectory continue unchanged; JATK lasts until landing; no return from JATK to JUMP.
REQ-018 key_left/key_right during JUMP/JATK do not change RyuX.
REQ-019 sprite mapping: IDLE 0 (or 0/1 per REQ-026), PUNCH 2, JUMP 3, CROUCH 4, WALK_L 5, WALK_R 6, DEATH 7, JATK 8; sprite updates on the same edge as the state register.
REQ-020 hit high on any cycle (tick not required) -> DEATH on the next edge from any state; RyuY forced to GROUND_Y, RyuX held; DEATH is terminal until reset; hit takes priority over simultaneous frame_tick.
REQ-021 Conflicting simultaneous keys resolve strictly by REQ-013 priority; no key latching between ticks.

Reset
REQ-022 reset_n low asynchronously forces: state IDLE, sprite 0, RyuX = X_MIN, RyuY = GROUND_Y, attack_active 0, busy 0, all counters 0.
REQ-023 Reset asserted mid-jump or mid-punch abandons the action immediately; no residual motion after release.
REQ-024 First frame_tick after reset release is evaluated per REQ-013.

Configuration
REQ-025 Macro RYU_IDLE_PULSE_EN selects the idle breathing animation.
REQ-026 Defined: in IDLE a pulse counter counts ticks; sprite toggles 0<->1 every PULSE_PERIOD ticks, starting at 0 on IDLE entry; counter cleared on leaving IDLE.
REQ-027 Undefined: pulse counter absent; IDLE always drives sprite 0; code 1 never produced.

Verification
REQ-028 Reset, key_right held 300 ticks -> sprite 6, RyuX increments by 2 per tick, stops at 560 with no wrap.
REQ-029 key_up one tick (defaults) -> sprite 3, RyuY 300->236 after 16 ticks, back to 300 after 32 ticks, busy high throughout, then sprite 0.
REQ-030 key_up, then key_punch at tick 5 of jump -> sprite 8 and attack_active 1 from that edge until landing at tick 32, RyuY profile unchanged.
REQ-031 key_punch with key_left simultaneously held -> sprite 2 for exactly 12 ticks, RyuX unchanged, then sprite 5.
REQ-032 hit pulsed mid-jump between ticks -> next edge sprite 7, RyuY 300, busy 0; further keys ignored until reset_n low, which yields sprite 0, RyuX 16.
REQ-033 RYU_IDLE_PULSE_EN defined, idle 60 ticks -> sprite 0 for ticks 0-29, 1 for 30-59; undefined -> sprite 0 constant.
